// File: rtl/score_ram_scheduler.sv
// score_ram_scheduler
// Arbitrates the single-port high-score RAM between the login reader (port A)
// and the game controller (port B). Port B may also do "update if greater" read-compare-writes.
// Only this block drives the RAM address, data and write-enable pins.

module score_ram_scheduler #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 7,
   parameter int RD_LAT    = 1,
   parameter int SCORE_MAX = 99
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_done,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_op,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_done,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_updated,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CMP,
      ST_WRITE,
      ST_DONE
   } state_t;

   localparam logic [DATA_W-1:0] MAX_V     = DATA_W'(SCORE_MAX);
   localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);

   state_t            state;
   logic              sel_b;
   logic              last_b;
   logic              upd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        wait_cnt;
   logic              pick_b;
   logic [DATA_W-1:0] b_wclamp;

   // B wins only when A is idle, or when both ask and A was served last.
   assign pick_b   = b_req && (!a_req || !last_b);
   // Candidate scores above the ceiling are stored as the ceiling.
   assign b_wclamp = (b_wdata > MAX_V) ? MAX_V : b_wdata;

   // Transaction sequencer: grant, address the RAM, wait out read latency, compare, optionally write, report.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         sel_b     <= 1'b0;
         last_b    <= 1'b1;
         upd_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wait_cnt  <= '0;
         a_done    <= 1'b0;
         a_rdata   <= '0;
         b_done    <= 1'b0;
         b_rdata   <= '0;
         b_updated <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (a_req || b_req) begin
                  sel_b   <= pick_b;
                  last_b  <= pick_b;
                  upd_q   <= pick_b && b_op;
                  addr_q  <= pick_b ? b_addr : a_addr;
                  wdata_q <= b_wclamp;
                  busy    <= 1'b1;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               ram_addr <= addr_q;
               ram_we   <= 1'b0;
               wait_cnt <= '0;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state <= ST_CMP;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            ST_CMP: begin
               if (upd_q && (wdata_q > ram_rdata)) begin
                  ram_we    <= 1'b1;
                  ram_wdata <= wdata_q;
                  state     <= ST_WRITE;
               end else begin
                  if (sel_b) begin
                     b_rdata   <= ram_rdata;
                     b_updated <= 1'b0;
                     b_done    <= 1'b1;
                  end else begin
                     a_rdata <= ram_rdata;
                     a_done  <= 1'b1;
                  end
                  state <= ST_DONE;
               end
            end
            ST_WRITE: begin
               ram_we    <= 1'b0;
               b_rdata   <= wdata_q;
               b_updated <= 1'b1;
               b_done    <= 1'b1;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               a_done <= 1'b0;
               b_done <= 1'b0;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               ram_we <= 1'b0;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_ram_scheduler.sv
// tb_score_ram_scheduler
// Drives both requesters against a behavioural score RAM and compares every result
// with a plain array model of the stored high scores.

module tb_score_ram_scheduler;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 7;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              a_req = 1'b0;
   logic [ADDR_W-1:0] a_addr = '0;
   logic              a_done;
   logic [DATA_W-1:0] a_rdata;
   logic              b_req = 1'b0;
   logic              b_op = 1'b0;
   logic [ADDR_W-1:0] b_addr = '0;
   logic [DATA_W-1:0] b_wdata = '0;
   logic              b_done;
   logic [DATA_W-1:0] b_rdata;
   logic              b_updated;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata = '0;
   logic              busy;

   logic              pre_we = 1'b0;
   logic [ADDR_W-1:0] pre_addr = '0;
   logic [DATA_W-1:0] pre_data = '0;
   logic [DATA_W-1:0] mem [16];

   int                refMem [16];
   int                checks = 0;
   int                errors = 0;
   int                weCount = 0;
   logic [ADDR_W-1:0] weAddr = '0;
   logic [DATA_W-1:0] weData = '0;

   score_ram_scheduler #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .SCORE_MAX(99)
   ) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_addr(a_addr), .a_done(a_done), .a_rdata(a_rdata),
      .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_done(b_done), .b_rdata(b_rdata), .b_updated(b_updated),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Score RAM with one clock of read latency; a bench-side port preloads contents.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else if (pre_we) mem[pre_addr] <= pre_data;
      ram_rdata <= mem[ram_addr];
   end

   // Record every cycle the RAM write enable is high, with its address and data.
   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         weCount = weCount + 1;
         weAddr  = ram_addr;
         weData  = ram_wdata;
      end
   end

   // One comparison: counts it and reports a failure with observed and expected values.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One complete request on port A or B, checked against the score model.
   task automatic applyStimulus(input bit portB, input bit op, input int addr, input int wdata, input string tag);
      int expData;
      int expUpd;
      int expLat;
      int lat;
      int base;
      int w;
      bit seen;
      expData = refMem[addr];
      expUpd  = 0;
      expLat  = 4;
      if (portB && op) begin
         w = (wdata > 99) ? 99 : wdata;
         if (w > refMem[addr]) begin
            refMem[addr] = w;
            expData = w;
            expUpd  = 1;
            expLat  = 5;
         end
      end
      base = weCount;
      if (portB) begin
         b_req = 1'b1; b_op = op; b_addr = ADDR_W'(addr); b_wdata = DATA_W'(wdata);
      end else begin
         a_req = 1'b1; a_addr = ADDR_W'(addr);
      end
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            a_addr  = ADDR_W'($urandom);
            b_addr  = ADDR_W'($urandom);
            b_wdata = DATA_W'($urandom);
         end
         if (portB ? (b_done === 1'b1) : (a_done === 1'b1)) seen = 1'b1;
      end
      checkOutput({tag, " done_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
         checkOutput({tag, " busy_at_done"}, 32'(busy), 32'd1);
         if (portB) begin
            checkOutput({tag, " b_rdata"}, 32'(b_rdata), 32'(expData));
            checkOutput({tag, " b_updated"}, 32'(b_updated), 32'(expUpd));
         end else begin
            checkOutput({tag, " a_rdata"}, 32'(a_rdata), 32'(expData));
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      @(negedge clk);
      checkOutput({tag, " done_pulse_end"}, 32'(a_done | b_done), 32'd0);
      checkOutput({tag, " busy_after"}, 32'(busy), 32'd0);
      checkOutput({tag, " write_count"}, 32'(weCount - base), 32'(expUpd));
      if (expUpd == 1) begin
         checkOutput({tag, " write_addr"}, 32'(weAddr), 32'(addr));
         checkOutput({tag, " write_data"}, 32'(weData), 32'(expData));
      end
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      int seq [$];
      int cnt;
      int base;
      bit seen;
      int v;

      $display("[TB] start");
      repeat (3) @(negedge clk);
      checkOutput("reset a_done", 32'(a_done), 32'd0);
      checkOutput("reset b_done", 32'(b_done), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset ram_we", 32'(ram_we), 32'd0);
      checkOutput("reset ram_addr", 32'(ram_addr), 32'd0);
      checkOutput("reset b_updated", 32'(b_updated), 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 16; i++) begin
         case (i)
            0: v = 99;
            1: v = 10;
            3: v = 42;
            5: v = 30;
            9: v = 20;
            default: v = int'($urandom_range(0, 99));
         endcase
         @(negedge clk);
         pre_we = 1'b1; pre_addr = ADDR_W'(i); pre_data = DATA_W'(v);
         refMem[i] = v;
      end
      @(negedge clk);
      pre_we = 1'b0;

      applyStimulus(1'b0, 1'b0, 3, 0, "a_read3");
      applyStimulus(1'b1, 1'b1, 5, 57, "b_upd5_57");
      applyStimulus(1'b1, 1'b1, 5, 57, "b_upd5_equal");
      applyStimulus(1'b1, 1'b1, 5, 12, "b_upd5_lower");
      applyStimulus(1'b1, 1'b1, 0, 120, "b_upd0_clamp_nowrite");
      applyStimulus(1'b1, 1'b1, 1, 120, "b_upd1_clamp_write");
      applyStimulus(1'b1, 1'b0, 1, 5, "b_read1");

      // Both requesters held from reset: grants must alternate starting with A.
      @(negedge clk);
      rst = 1'b0;
      a_req = 1'b1; a_addr = 4'd2;
      b_req = 1'b1; b_addr = 4'd7; b_op = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      while (seq.size() < 4 && cnt < 60) begin
         @(negedge clk);
         cnt++;
         if (a_done === 1'b1 && b_done === 1'b1) seq.push_back(2);
         else if (a_done === 1'b1) begin
            seq.push_back(0);
            checkOutput("rr a_rdata", 32'(a_rdata), 32'(refMem[2]));
         end else if (b_done === 1'b1) begin
            seq.push_back(1);
            checkOutput("rr b_rdata", 32'(b_rdata), 32'(refMem[7]));
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      checkOutput("rr done_count", 32'(seq.size()), 32'd4);
      for (int i = 0; i < seq.size(); i++) begin
         checkOutput("rr grant_order", 32'(seq[i]), 32'(i % 2));
      end
      repeat (2) @(negedge clk);

      // Reset asserted while the write enable is high must abort the write.
      base = weCount;
      b_req = 1'b1; b_op = 1'b1; b_addr = 4'd9; b_wdata = 7'd77;
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (ram_we === 1'b1) seen = 1'b1;
      end
      checkOutput("abort we_seen", 32'(seen), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("abort ram_we", 32'(ram_we), 32'd0);
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort b_done", 32'(b_done), 32'd0);
      b_req = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (b_done === 1'b1 || a_done === 1'b1) seen = 1'b1;
      end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (b_done === 1'b1 || a_done === 1'b1) seen = 1'b1;
      end
      checkOutput("abort no_late_done", 32'(seen), 32'd0);
      checkOutput("abort single_we_cycle", 32'(weCount - base), 32'd1);

      a_req = 1'b1; a_addr = 4'd9;
      b_req = 1'b1; b_addr = 4'd3; b_op = 1'b0;
      cnt = 0;
      v = -1;
      while (v < 0 && cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (a_done === 1'b1) v = 0;
         else if (b_done === 1'b1) v = 1;
      end
      checkOutput("post_reset first_grant", 32'(v), 32'd0);
      checkOutput("post_reset a_rdata", 32'(a_rdata), 32'(refMem[9]));
      a_req = 1'b0;
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (b_done === 1'b1) seen = 1'b1;
      end
      checkOutput("post_reset b_done", 32'(seen), 32'd1);
      checkOutput("post_reset b_rdata", 32'(b_rdata), 32'(refMem[3]));
      b_req = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 127)), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
